pattern_sequence_detector: RTL
==============================

PATTERN_SEQUENCE_DETECTOR -- requirements
Module: pattern_sequence_detector

Interface
REQ-001 Parameter WIDTH, default 2: pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN_INIT, default 2'b11: pattern register value after reset.
REQ-003 Parameter CNT_W, default 8: match counter width; legal range 2..16.
REQ-004 Parameter MOORE, default 0: 0 = Mealy (combinational) out, 1 = Moore (registered) out.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-007 in_valid  input  1  in is sampled only when 1.
REQ-008 in  input  1  serial data bit.
REQ-009 overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-010 pat_load  input  1  loads pat_in into pattern register.
REQ-011 pat_in  input  WIDTH  new pattern; MSB is the first bit received.
REQ-012 clr_count  input  1  synchronous clear of match_count.
REQ-013 out  output  1  match pulse.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 count_sat  output  1  1 while match_count equals all-ones.

Function
REQ-016 State: pattern register (WIDTH), history shift register (WIDTH-1 bits, newest bit at LSB), fill counter (0..WIDTH-1, saturating), match counter.
REQ-017 Candidate word = {history, in}; match = in_valid & (fill == WIDTH-1) & (candidate == pattern) & ~pat_load.
REQ-018 On a clk edge with in_valid=1 and pat_load=0: history shifts in, fill increments up to WIDTH-1, then holds.
REQ-019 in_valid=0: history, fill and match state hold; in is ignored; no match.
REQ-020 overlap=1: on a match, fill stays at WIDTH-1, so the next valid bit can complete another match.
REQ-021 overlap=0: on a match, fill clears to 0 on that edge, so the next match needs WIDTH fresh valid bits.
REQ-022 MOORE=0: out = match combinationally, in the same cycle the completing bit is presented.
REQ-023 MOORE=1: out is a register loaded with match, high for exactly the one cycle after the completing edge.
REQ-024 pat_load=1: pattern <= pat_in, history and fill clear to 0, in is ignored that cycle, no match; match_count unaffected.
REQ-025 Each match increments match_count by 1; at all-ones it holds (no wrap).
REQ-026 clr_count=1: match_count <= 0, taking priority over a simultaneous match increment.
REQ-027 pat_load and clr_count asserted together: both take effect on the same edge.
REQ-028 overlap may change on any cycle; it affects only the match sampled on that edge.

Reset
REQ-029 reset=0: pattern=PATTERN_INIT; history, fill and match_count = 0; out=0; count_sat=0, all asynchronously, without waiting for a clock edge.
REQ-030 Reset asserted during partial accumulation discards all accumulated bits; detection restarts from fill=0 after release.
REQ-031 The first edge after reset release is a normal operating edge.

Verification
REQ-032 Defaults (pattern 11, MOORE=0), overlap=1, valid stream 0,1,1,1,0 -> out high during bits 3 and 4; match_count=2.
REQ-033 Defaults, stream 1,1,1,1: overlap=1 -> out on bits 2,3,4, match_count=3; overlap=0 -> out on bits 2,4, match_count=2.
REQ-034 WIDTH=4, pat_load with pat_in=1101, stream 1,1,0,1,1,0,1: overlap=1 -> out on bits 4 and 7; overlap=0 -> out on bit 4 only; MOORE=1 -> each pulse one cycle later.
REQ-035 Defaults, stream 1, then three cycles in_valid=0 with in=1, then 1 -> exactly one out pulse, on the final valid bit.
REQ-036 CNT_W=2, overlap=1, six consecutive 1s -> match_count=3 with count_sat=1 after the fourth 1 and held; then clr_count -> match_count=0, count_sat=0.
REQ-037 Defaults, valid 1, then reset=0 mid-cycle -> out, fill and count are 0 before the next edge; after release, a single 1 -> no match; a second 1 -> match.

Source files
------------

// File: rtl/pattern_sequence_detector.sv
// Serial pattern detector with programmable pattern, overlap control and saturating match counter.
// Mealy out is combinational with the completing bit, Moore out lags one cycle; no backpressure, in_valid_i gates sampling.
module pattern_sequence_detector #(
    parameter int               WIDTH        = 2,
    parameter logic [WIDTH-1:0] PATTERN_INIT = 2'b11,
    parameter int               CNT_W        = 8,
    parameter int               MOORE        = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic             in_i,
    input  logic             overlap_i,
    input  logic             pat_load_i,
    input  logic [WIDTH-1:0] pat_in_i,
    input  logic             clr_count_i,
    output logic             out_o,
    output logic [CNT_W-1:0] match_count_o,
    output logic             count_sat_o
);

    localparam int               FW       = $clog2(WIDTH);
    localparam logic [FW-1:0]    FILL_MAX = FW'(WIDTH - 1);

    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [WIDTH-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             moore_q, moore_d;
    logic [WIDTH-1:0] cand;
    logic             match;

    always_comb begin
        cand      = {hist_q, in_i};
        match     = in_valid_i & (fill_q == FILL_MAX) & (cand == pattern_q) & ~pat_load_i;
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        moore_d   = match;

        if (pat_load_i) begin
            pattern_d = pat_in_i;
            hist_d    = '0;
            fill_d    = '0;
        end else if (in_valid_i) begin
            hist_d = cand[WIDTH-2:0];
            // Non-overlapping mode forces a full refill of WIDTH fresh bits after each hit.
            if (match && !overlap_i) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (clr_count_i) begin
            cnt_d = '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pattern_q <= PATTERN_INIT;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            moore_q   <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            moore_q   <= moore_d;
        end
    end

    assign out_o         = (MOORE != 0) ? moore_q : match;
    assign match_count_o = cnt_q;
    assign count_sat_o   = &cnt_q;

endmodule
